// File: rtl/tmds_channel_decoder.sv
// One-channel TMDS receive decoder: aligns the deserializer with bit-slip requests
// driven by control-token runs, then decodes video bytes, control bits and guard bands.
module tmds_channel_decoder #(
  parameter int CHANNEL       = 0,
  parameter int SEARCH_WINDOW = 4096,
  parameter int LOCK_RUN      = 8,
  parameter int SLIP_SETTLE   = 4,
  parameter int LOSS_WINDOWS  = 2
) (
  input  logic       pixelClock,
  input  logic       reset,
  input  logic [9:0] tmdsWord,
  output logic       bitSlip,
  output logic [3:0] slipCount,
  output logic       locked,
  output logic       dataEnable,
  output logic [7:0] data,
  output logic       c0,
  output logic       c1,
  output logic       controlValid,
  output logic       guardBand
);

  localparam int WIN_W    = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int RUN_W    = $clog2(LOCK_RUN + 1);
  localparam int SETTLE_W = (SLIP_SETTLE > 1) ? $clog2(SLIP_SETTLE) : 1;
  localparam int MISS_W   = $clog2(LOSS_WINDOWS + 1);
  localparam logic [9:0] GUARD_TOKEN = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;

  typedef enum logic [1:0] {SEARCH, SLIP, SETTLE, LOCKED} stateT;
  typedef enum logic [1:0] {CONTROL, VIDEO_PENDING, VIDEO} periodT;

  stateT               state;
  periodT              period;
  logic [WIN_W-1:0]    windowCount;
  logic [RUN_W-1:0]    runCount;
  logic [SETTLE_W-1:0] settleCount;
  logic [MISS_W-1:0]   missedWindows;

  logic             isControl;
  logic             isGuard;
  logic [1:0]       ctrlBits;
  logic [7:0]       q;
  logic [7:0]       decoded;
  logic [RUN_W-1:0] runNext;
  logic             runDone;
  logic             windowExpired;

  always_comb begin
    isControl = 1'b1;
    ctrlBits  = 2'b00;
    case (tmdsWord)
      10'b1101010100: ctrlBits = 2'b00;
      10'b0010101011: ctrlBits = 2'b01;
      10'b0101010100: ctrlBits = 2'b10;
      10'b1010101011: ctrlBits = 2'b11;
      default:        isControl = 1'b0;
    endcase
  end

  assign isGuard = (tmdsWord == GUARD_TOKEN);

  always_comb begin
    q          = tmdsWord[9] ? ~tmdsWord[7:0] : tmdsWord[7:0];
    decoded    = '0;
    decoded[0] = q[0];
    for (int unsigned i = 1; i < 8; i++)
      decoded[i] = tmdsWord[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
  end

  assign runNext       = isControl ? runCount + 1'b1 : '0;
  assign runDone       = (runNext == RUN_W'(LOCK_RUN));
  assign windowExpired = (windowCount == WIN_W'(SEARCH_WINDOW - 1));

  always_ff @(posedge pixelClock) begin
    if (reset) begin
      state         <= SEARCH;
      period        <= CONTROL;
      windowCount   <= '0;
      runCount      <= '0;
      settleCount   <= '0;
      missedWindows <= '0;
      bitSlip       <= 1'b0;
      slipCount     <= '0;
      locked        <= 1'b0;
      dataEnable    <= 1'b0;
      data          <= '0;
      c0            <= 1'b0;
      c1            <= 1'b0;
      controlValid  <= 1'b0;
      guardBand     <= 1'b0;
    end else begin
      bitSlip <= (state == SLIP);
      locked  <= (state == LOCKED);

      if (state == LOCKED) begin
        data         <= decoded;
        controlValid <= isControl;
        guardBand    <= isGuard;
        dataEnable   <= 1'b0;
        if (isControl) begin
          c0     <= ctrlBits[0];
          c1     <= ctrlBits[1];
          period <= CONTROL;
        end else if (isGuard) begin
          period <= VIDEO_PENDING;
        end else if (period != CONTROL) begin
          period     <= VIDEO;
          dataEnable <= 1'b1;
        end
      end else begin
        data         <= '0;
        controlValid <= 1'b0;
        guardBand    <= 1'b0;
        dataEnable   <= 1'b0;
        period       <= CONTROL;
      end

      case (state)
        SEARCH: begin
          runCount <= runNext;
          if (runDone) begin
            state         <= LOCKED;
            runCount      <= '0;
            windowCount   <= '0;
            missedWindows <= '0;
          end else if (windowExpired) begin
            state <= SLIP;
          end else begin
            windowCount <= windowCount + 1'b1;
          end
        end
        SLIP: begin
          slipCount   <= (slipCount == 4'd9) ? 4'd0 : slipCount + 4'd1;
          settleCount <= '0;
          state       <= SETTLE;
        end
        SETTLE: begin
          runCount    <= '0;
          windowCount <= '0;
          if (settleCount == SETTLE_W'(SLIP_SETTLE - 1))
            state <= SEARCH;
          else
            settleCount <= settleCount + 1'b1;
        end
        LOCKED: begin
          // A completed run refreshes lock even when the window expires on the same word.
          runCount <= runNext;
          if (runDone) begin
            runCount      <= '0;
            windowCount   <= '0;
            missedWindows <= '0;
          end else if (windowExpired) begin
            windowCount <= '0;
            if (missedWindows == MISS_W'(LOSS_WINDOWS - 1)) begin
              state         <= SEARCH;
              missedWindows <= '0;
              runCount      <= '0;
            end else begin
              missedWindows <= missedWindows + 1'b1;
            end
          end else begin
            windowCount <= windowCount + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Randomized bench for tmds_channel_decoder: a word-level reference model is stepped
// every cycle alongside directed alignment, lock-loss, slip-cadence and reset scenarios.
module tb_tmds_channel_decoder;
  localparam int SW = 4096;
  localparam int LR = 8;
  localparam int SS = 4;
  localparam int LW = 2;
  localparam int PERIOD_WORDS = 1650;
  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] GUARD = 10'b1011001100;
  localparam int M_SEARCH = 0, M_SLIP = 1, M_SETTLE = 2, M_LOCKED = 3;
  localparam int P_CTRL = 0, P_PEND = 1, P_VIDEO = 2;

  logic       pixelClock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] tmdsWord = '0;
  logic       bitSlip, locked, dataEnable, c0, c1, controlValid, guardBand;
  logic [3:0] slipCount;
  logic [7:0] data;

  tmds_channel_decoder #(
    .CHANNEL(0), .SEARCH_WINDOW(SW), .LOCK_RUN(LR), .SLIP_SETTLE(SS), .LOSS_WINDOWS(LW)
  ) dut (
    .pixelClock(pixelClock), .reset(reset), .tmdsWord(tmdsWord), .bitSlip(bitSlip),
    .slipCount(slipCount), .locked(locked), .dataEnable(dataEnable), .data(data),
    .c0(c0), .c1(c1), .controlValid(controlValid), .guardBand(guardBand)
  );

  always #5 pixelClock = ~pixelClock;

  int vectorsApplied = 0;
  int miscompares = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorsApplied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int mode = M_SEARCH, mWin = 0, mRun = 0, mSettle = 0, mMiss = 0, mSlip = 0, mPeriod = P_CTRL;
  logic eBitSlip = 0, eLocked = 0, eDe = 0, eC0 = 0, eC1 = 0, eCv = 0, eGb = 0;
  logic [7:0] eData = '0;
  logic [9:0] dataTab [PERIOD_WORDS];

  logic [18:0] outVec, expVec;
  assign outVec = {bitSlip, slipCount, locked, dataEnable, data, c1, c0, controlValid, guardBand};
  assign expVec = {eBitSlip, 4'(mSlip), eLocked, eDe, eData, eC1, eC0, eCv, eGb};

  function automatic int ctrlIndex(input logic [9:0] w);
    logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    for (int i = 0; i < 4; i++)
      if (w == toks[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] refDecode(input logic [9:0] w);
    logic [7:0] qv, x;
    qv = w[9] ? ~w[7:0] : w[7:0];
    x = qv ^ {qv[6:0], 1'b0};
    if (!w[8]) x = x ^ 8'hFE;
    return x;
  endfunction

  function automatic logic [9:0] randData();
    logic [9:0] w;
    do w = 10'($urandom); while (ctrlIndex(w) >= 0 || w == GUARD);
    return w;
  endfunction

  function automatic logic [9:0] txWord(input int n);
    int m = n % PERIOD_WORDS;
    return (m < 12) ? TOK00 : dataTab[m];
  endfunction

  // Deserializer view: ten serial bits starting at absolute bit position p.
  function automatic logic [9:0] wordAt(input int p);
    logic [9:0] w, t;
    for (int b = 0; b < 10; b++) begin
      t = txWord((p + b) / 10);
      w[b] = t[(p + b) % 10];
    end
    return w;
  endfunction

  task automatic modelStep(input logic [9:0] w, input logic rst);
    int k;
    bit g;
    if (rst) begin
      mode = M_SEARCH; mWin = 0; mRun = 0; mSettle = 0; mMiss = 0; mSlip = 0; mPeriod = P_CTRL;
      eBitSlip = 0; eLocked = 0; eDe = 0; eC0 = 0; eC1 = 0; eCv = 0; eGb = 0; eData = '0;
      return;
    end
    k = ctrlIndex(w);
    g = (w == GUARD);
    eBitSlip = (mode == M_SLIP);
    eLocked = (mode == M_LOCKED);
    eDe = 0; eCv = 0; eGb = 0; eData = '0;
    if (mode == M_LOCKED) begin
      eData = refDecode(w);
      eCv = (k >= 0);
      eGb = g;
      if (k >= 0) begin
        eC0 = k[0]; eC1 = k[1]; mPeriod = P_CTRL;
      end else if (g) mPeriod = P_PEND;
      else if (mPeriod != P_CTRL) begin
        mPeriod = P_VIDEO; eDe = 1;
      end
    end else mPeriod = P_CTRL;

    if (mode == M_SEARCH || mode == M_LOCKED) begin
      mRun = (k >= 0) ? mRun + 1 : 0;
      if (mRun == LR) begin
        mode = M_LOCKED; mRun = 0; mWin = 0; mMiss = 0;
      end else if (mWin == SW - 1) begin
        if (mode == M_SEARCH) mode = M_SLIP;
        else begin
          mWin = 0;
          mMiss++;
          if (mMiss == LW) begin mode = M_SEARCH; mMiss = 0; mRun = 0; end
        end
      end else mWin++;
    end else if (mode == M_SLIP) begin
      mSlip = (mSlip + 1) % 10; mSettle = 0; mode = M_SETTLE;
    end else begin
      mRun = 0; mWin = 0;
      if (mSettle == SS - 1) mode = M_SEARCH;
      else mSettle++;
    end
  endtask

  task automatic tick(input logic [9:0] w);
    tmdsWord = w;
    @(posedge pixelClock);
    modelStep(w, reset);
    #1;
    checkVal("outs", 32'(outVec), 32'(expVec));
  endtask

  initial begin
    int firstLock, dropAt, slips, pulses, lastPulse, lockedSeen, p, cyc;
    foreach (dataTab[i]) dataTab[i] = randData();

    // Reset state
    reset = 1'b1;
    repeat (3) tick(randData());
    checkVal("resetState", 32'(outVec), 0);
    reset = 1'b0;

    // Aligned stream: lock latency, guard band, video decode
    firstLock = -1;
    for (int i = 0; i < 20; i++) begin
      tick(TOK00);
      if (locked && firstLock < 0) firstLock = i;
    end
    checkVal("lockLatency", 32'(firstLock), 8);
    tick(GUARD);
    checkVal("guardBand", {dataEnable, guardBand}, 2'b01);
    tick(GUARD);
    tick(10'b0100000000);
    checkVal("video00", {dataEnable, data}, {1'b1, 8'h00});
    tick(10'b1000000000);
    checkVal("videoFF", {dataEnable, data, c1, c0}, {1'b1, 8'hFF, 2'b00});

    // Control bits sequence
    tick(10'b1010101011);
    checkVal("ctrl11", {c1, c0, controlValid, dataEnable}, 4'b1110);
    tick(10'b0010101011);
    checkVal("ctrl01", {c1, c0, controlValid, dataEnable}, 4'b0110);

    // Randomized locked traffic
    cyc = 0;
    while (cyc < 3000) begin
      case ($urandom_range(0, 9))
        0: begin
          for (int j = 0; j < LR; j++) begin
            logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
            tick(toks[$urandom_range(0, 3)]);
          end
          cyc += LR;
        end
        1: begin tick(GUARD); cyc++; end
        2: begin tick(10'b0101010100); cyc++; end
        default: begin tick(10'($urandom)); cyc++; end
      endcase
    end
    checkVal("lockedAfterRandom", 32'(locked), 1);

    // Reset while locked
    reset = 1'b1;
    tick(TOK00);
    checkVal("resetLocked", 32'(outVec), 0);
    reset = 1'b0;

    // Relock, then remove control tokens
    repeat (20) tick(TOK00);
    checkVal("relocked", 32'(locked), 1);
    dropAt = -1;
    slips = 0;
    for (int i = 0; i < 8400; i++) begin
      tick(randData());
      if (bitSlip) slips++;
      if (!locked && dropAt < 0) dropAt = i;
      if (i == 4200) checkVal("lockHeldOneMiss", 32'(locked), 1);
    end
    checkVal("lossTiming", 32'(dropAt >= 8100 && dropAt <= 8200), 1);
    checkVal("noSlipOnLoss", 32'(slips), 0);
    checkVal("forcedAfterLoss", {dataEnable, controlValid, guardBand, data}, '0);

    // Runs one short of LOCK_RUN: slip cadence, then reset during a slip pulse
    reset = 1'b1;
    tick(TOK00);
    reset = 1'b0;
    pulses = 0;
    lastPulse = 0;
    lockedSeen = 0;
    for (int i = 0; i < 20000 && pulses < 3; i++) begin
      tick((i % 8 < 7) ? TOK00 : randData());
      if (locked) lockedSeen = 1;
      if (bitSlip) begin
        if (pulses > 0) checkVal("slipCadence", 32'(i - lastPulse), SW + 1 + SS);
        pulses++;
        lastPulse = i;
      end
    end
    checkVal("slipPulses", 32'(pulses), 3);
    checkVal("noFalseLock", 32'(lockedSeen), 0);
    reset = 1'b1;
    tick(TOK00);
    checkVal("resetInSlip", 32'(outVec), 0);
    reset = 1'b0;

    // Stream rotated by 3 bits; the model deserializer applies each slip
    reset = 1'b1;
    tick(TOK00);
    reset = 1'b0;
    p = 3;
    slips = 0;
    lastPulse = -100;
    for (int i = 0; i < 40000 && !locked; i++) begin
      tick(wordAt(p));
      p += 10;
      if (bitSlip) begin
        if (slips > 0) checkVal("slipSpacing", 32'(i - lastPulse >= SS + 1), 1);
        slips++;
        lastPulse = i;
        p += 1;
      end
    end
    checkVal("rotLocked", 32'(locked), 1);
    checkVal("rotSlips", 32'(slips), 7);
    checkVal("rotSlipCount", 32'(slipCount), 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
